// File: rtl/excp_pkg.sv
// Shared exception codes, access-size decode and FSM state type for the EX exception unit.
package excp_pkg;

  localparam logic [6:0] ECODE_ADEF = 7'h8;
  localparam logic [6:0] ECODE_ALE  = 7'h9;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } mem_size_e;

  typedef enum logic {
    IDLE,
    REPORT
  } excp_state_e;

  function automatic mem_size_e decode_size(input logic [2:0] mem_type);
    if (mem_type[2:1] == 2'b00) return SIZE_WORD;
    else if (mem_type[0])       return SIZE_HALF;
    else                        return SIZE_BYTE;
  endfunction

endpackage

// File: rtl/excp_lane_chk.sv
// Per-lane exception merge: upstream code, misaligned-access detection and BADV selection.
// Misalignment checking is built only when EXCP_ALE_CHECK_EN is defined.
module excp_lane_chk
  import excp_pkg::*;
#(
  parameter int ECODE_W = 7
) (
  input  logic               in_valid,
  input  logic [31:0]        pc,
  input  logic [ECODE_W-1:0] ecode_in,
  input  logic               ecode_we,
  input  logic               mem_rvalid,
  input  logic               mem_wvalid,
  input  logic [31:0]        mem_addr,
  input  logic [2:0]         mem_type,
  output logic [ECODE_W-1:0] ecode,
  output logic               excp,
  output logic [31:0]        badv,
  output logic               badv_we
);

  logic ale;

`ifdef EXCP_ALE_CHECK_EN
  mem_size_e size;
  assign size = decode_size(mem_type);
  assign ale  = in_valid & (mem_rvalid | mem_wvalid) &
                (((size == SIZE_WORD) & (mem_addr[1:0] != 2'b00)) |
                 ((size == SIZE_HALF) & mem_addr[0]));
`else
  // Unaligned accesses are resolved by the memory system in this build.
  logic unused_mem_info;
  assign unused_mem_info = ^{mem_type, mem_rvalid, mem_wvalid};
  assign ale = 1'b0;
`endif

  always_comb begin
    ecode   = '0;
    excp    = 1'b0;
    badv    = '0;
    badv_we = 1'b0;
    if (in_valid) begin
      if (ecode_we) begin
        ecode = ecode_in;
        excp  = 1'b1;
      end else if (ale) begin
        ecode = ECODE_W'(ECODE_ALE);
        excp  = 1'b1;
      end
      if (ecode_we && (ecode_in == ECODE_W'(ECODE_ADEF))) begin
        badv    = pc;
        badv_we = 1'b1;
      end else if (ale) begin
        badv    = mem_addr;
        badv_we = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_excp_unit.sv
// EX->MEM exception unit: oldest-lane priority/kill, CSR write mask, MEM output registers
// and the exception report handshake. ALE detection controlled by EXCP_ALE_CHECK_EN.
//
// state  | meaning
// IDLE   | capturing EX bundles into MEM when not stalled
// REPORT | exception report held for the CSR unit, front-end stalled until excp_ack
module ex_excp_unit
  import excp_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int ECODE_W  = 7,
  parameter int CSR_LANE = 1,
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*32-1:0]      pc,
  input  logic [LANES*ECODE_W-1:0] ecode_in,
  input  logic [LANES-1:0]         ecode_we,
  input  logic [LANES-1:0]         mem_rvalid,
  input  logic [LANES-1:0]         mem_wvalid,
  input  logic [LANES*32-1:0]      mem_addr,
  input  logic [LANES*3-1:0]       mem_type,
  input  logic [2:0]               csr_type,
  input  logic [31:0]              rf_rdata1,
  input  logic [31:0]              rf_rdata2,
  output logic [LANES-1:0]         out_valid,
  output logic [LANES*ECODE_W-1:0] out_ecode,
  output logic [LANES-1:0]         out_ecode_we,
  output logic [LANES*32-1:0]      out_badv,
  output logic [LANES-1:0]         out_badv_we,
  output logic [31:0]              csr_we,
  output logic [31:0]              csr_wdata,
  output logic                     excp_valid,
  output logic [LANE_W-1:0]        excp_lane,
  output logic [ECODE_W-1:0]       excp_ecode,
  output logic [31:0]              excp_pc,
  output logic [31:0]              excp_badv,
  input  logic                     excp_ack,
  output logic                     stall_req
);

  logic [LANES*ECODE_W-1:0] lane_ecode;
  logic [LANES-1:0]         lane_excp;
  logic [LANES*32-1:0]      lane_badv;
  logic [LANES-1:0]         lane_badv_we;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    excp_lane_chk #(.ECODE_W(ECODE_W)) u_chk (
      .in_valid   (in_valid[l]),
      .pc         (pc[l*32 +: 32]),
      .ecode_in   (ecode_in[l*ECODE_W +: ECODE_W]),
      .ecode_we   (ecode_we[l]),
      .mem_rvalid (mem_rvalid[l]),
      .mem_wvalid (mem_wvalid[l]),
      .mem_addr   (mem_addr[l*32 +: 32]),
      .mem_type   (mem_type[l*3 +: 3]),
      .ecode      (lane_ecode[l*ECODE_W +: ECODE_W]),
      .excp       (lane_excp[l]),
      .badv       (lane_badv[l*32 +: 32]),
      .badv_we    (lane_badv_we[l])
    );
  end

  logic               any_excp;
  logic [LANES-1:0]   kill;
  logic [LANE_W-1:0]  sel_lane;
  logic [ECODE_W-1:0] sel_ecode;
  logic [31:0]        sel_pc;
  logic [31:0]        sel_badv;

  always_comb begin
    any_excp  = 1'b0;
    kill      = '0;
    sel_lane  = '0;
    sel_ecode = '0;
    sel_pc    = '0;
    sel_badv  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (any_excp) begin
        kill[l] = 1'b1;
      end else if (lane_excp[l]) begin
        any_excp  = 1'b1;
        sel_lane  = LANE_W'(l);
        sel_ecode = lane_ecode[l*ECODE_W +: ECODE_W];
        sel_pc    = pc[l*32 +: 32];
        sel_badv  = lane_badv[l*32 +: 32];
      end
    end
  end

  // A CSR write only retires when no older-or-same lane raised an exception.
  logic        csr_block;
  logic [31:0] csr_we_d;
  logic [31:0] csr_wdata_d;
  logic        unused_csr_bit;

  always_comb begin
    csr_block = ~in_valid[CSR_LANE];
    for (int l = 0; l <= CSR_LANE; l++) csr_block = csr_block | lane_excp[l];
  end

  assign csr_we_d       = csr_block ? '0 : ({32{csr_type[1]}} | ({32{csr_type[2]}} & rf_rdata1));
  assign csr_wdata_d    = csr_block ? '0 : rf_rdata2;
  assign unused_csr_bit = csr_type[0];

  excp_state_e state_q, state_d;
  logic        capture;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        capture = !stall && !flush;
        if (capture && any_excp) state_d = REPORT;
      end
      REPORT: begin
        if (excp_ack) state_d = IDLE;
      end
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid    <= '0;
      out_ecode    <= '0;
      out_ecode_we <= '0;
      out_badv     <= '0;
      out_badv_we  <= '0;
      csr_we       <= '0;
      csr_wdata    <= '0;
      excp_lane    <= '0;
      excp_ecode   <= '0;
      excp_pc      <= '0;
      excp_badv    <= '0;
    end else if (capture) begin
      out_valid    <= in_valid & ~kill;
      out_ecode    <= lane_ecode;
      out_ecode_we <= lane_excp;
      out_badv     <= lane_badv;
      out_badv_we  <= lane_badv_we;
      csr_we       <= csr_we_d;
      csr_wdata    <= csr_wdata_d;
      if (any_excp) begin
        excp_lane  <= sel_lane;
        excp_ecode <= sel_ecode;
        excp_pc    <= sel_pc;
        excp_badv  <= sel_badv;
      end
    end else if ((state_q == REPORT) && !stall) begin
      // MEM consumed the excepting bundle once; do not replay it.
      out_valid <= '0;
    end
  end

  assign excp_valid = (state_q == REPORT);
  assign stall_req  = excp_valid;

endmodule
